// File: rtl/exec_unit_mc.sv
// Multi-cycle execute unit: single-cycle ALU/shift ops, iterative unsigned divide,
// internal Hi/Lo registers and a valid/ready request handshake.
module exec_unit_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpSlt  = 4'd4;
    localparam logic [3:0] OpSrl  = 4'd5;
    localparam logic [3:0] OpSll  = 4'd6;
    localparam logic [3:0] OpDivu = 4'd7;
    localparam logic [3:0] OpMfhi = 4'd8;
    localparam logic [3:0] OpMflo = 4'd9;

    typedef enum logic {StIdle, StDiv} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             accept;

    assign in_ready  = (state_q == StIdle) && reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Quotient bits enter quo_q from the bottom as dividend bits leave from the top.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        qbit      = ~trial[WIDTH];
        rem_next  = qbit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            OpAnd:   alu_res = dataA & dataB;
            OpOr:    alu_res = dataA | dataB;
            OpAdd:   alu_res = dataA + dataB;
            OpSub:   alu_res = dataA - dataB;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            OpSrl:   alu_res = dataB >> shamt;
            OpSll:   alu_res = dataB << shamt;
            OpDivu:  alu_res = '1;
            OpMfhi:  alu_res = hi_q;
            OpMflo:  alu_res = lo_q;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpDivu && dataB != '0) begin
                        dvs_d   = dataB;
                        quo_d   = dataA;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = StDiv;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = alu_res;
                        zero_d      = (alu_res == '0);
                        illegal_d   = alu_ill;
                        if (op == OpDivu) begin
                            lo_d = '1;
                            hi_d = dataA;
                        end
                    end
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d     = StIdle;
                        lo_d        = quo_next;
                        hi_d        = rem_next;
                        out_valid_d = 1'b1;
                        out_data_d  = quo_next;
                        zero_d      = (quo_next == '0);
                        illegal_d   = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: directed corner cases plus randomized ops against a
// behavioural model, on a 32-bit instance and an 8-bit instance.
module tb_exec_unit_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] out_data;

    logic        v8, flush8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic [2:0]  sh8;
    logic        rdy8, ov8, z8, ill8;
    logic [7:0]  od8;

    exec_unit_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .dataA(a), .dataB(b), .shamt(sh), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .zero(zero), .illegal(illegal)
    );

    exec_unit_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .op(op8),
        .dataA(a8), .dataB(b8), .shamt(sh8), .flush(flush8), .out_valid(ov8),
        .out_data(od8), .zero(z8), .illegal(ill8)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct packed {
        logic [31:0] d;
        logic        ill;
    } res_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] s);
        res_t r;
        r.ill = 1'b0;
        case (o)
            4'd0: r.d = x & y;
            4'd1: r.d = x | y;
            4'd2: r.d = x + y;
            4'd3: r.d = x - y;
            4'd4: r.d = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd5: r.d = y >> s;
            4'd6: r.d = y << s;
            4'd7: r.d = (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd8: r.d = m_hi;
            4'd9: r.d = m_lo;
            default: begin r.d = 32'd0; r.ill = 1'b1; end
        endcase
        return r;
    endfunction

    // Entered and left on a negedge; the next call issues back-to-back.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] s);
        res_t r;
        int   k;
        r = model(o, x, y, s);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; a = x; b = y; sh = s;
        @(negedge clk);
        in_valid = 1'b0;
        if (o == 4'd7 && y != 0) begin
            k = 1;
            while (out_valid !== 1'b1 && k < 40) begin
                chk("div_busy_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
                k++;
            end
            chk("div_latency", 64'(k), 64'd33);
            chk("div_ready_back", 64'(in_ready), 64'd1);
            m_lo = x / y;
            m_hi = x % y;
        end else if (o == 4'd7) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = x;
        end
        chk($sformatf("out_valid op%0d", o), 64'(out_valid), 64'd1);
        chk($sformatf("out_data op%0d", o), 64'(out_data), 64'(r.d));
        chk($sformatf("zero op%0d", o), 64'(zero), 64'(r.d == 0));
        chk($sformatf("illegal op%0d", o), 64'(illegal), 64'(r.ill));
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        int          pulses, k;
        logic [31:0] held, x, y;
        logic [3:0]  o;
        logic [7:0]  x8, y8;

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; sh = '0;
        v8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; sh8 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0);
        run_op(4'd3, 32'd5, 32'd5, 5'd0);
        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0);
        run_op(4'd5, 32'd0, 32'h8000_0000, 5'd31);
        run_op(4'd6, 32'd0, 32'd1, 5'd4);
        run_op(4'd12, 32'd3, 32'd4, 5'd0);
        @(negedge clk);
        chk("hold_out_valid", 64'(out_valid), 64'd0);
        chk("hold_illegal", 64'(illegal), 64'd1);
        run_op(4'd7, 32'd100, 32'd7, 5'd0);
        chk("divu_100_7", 64'(out_data), 64'd14);
        run_op(4'd8, 32'd0, 32'd0, 5'd0);
        chk("mfhi_2", 64'(out_data), 64'd2);
        run_op(4'd9, 32'd0, 32'd0, 5'd0);
        run_op(4'd7, 32'd9, 32'd0, 5'd0);
        chk("div0_ready", 64'(in_ready), 64'd1);
        run_op(4'd8, 32'd0, 32'd0, 5'd0);
        chk("mfhi_9", 64'(out_data), 64'd9);

        // Flush in IDLE must not block an accept.
        flush = 1'b1;
        run_op(4'd1, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
        flush = 1'b0;
        held = out_data;

        // Flush mid-divide.
        in_valid = 1'b1; op = 4'd7; a = 32'd100; b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_no_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_hold_data", 64'(out_data), 64'(held));
        count_pulses(40, pulses);
        chk("flush_pulses", 64'(pulses), 64'd0);
        run_op(4'd9, 32'd0, 32'd0, 5'd0);

        // Reset mid-divide.
        in_valid = 1'b1; op = 4'd7; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        count_pulses(40, pulses);
        chk("rst_mid_pulses", 64'(pulses), 64'd0);
        run_op(4'd8, 32'd0, 32'd0, 5'd0);
        run_op(4'd9, 32'd0, 32'd0, 5'd0);

        for (int i = 0; i < 60; i++) begin
            o = ($urandom_range(0, 4) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = $urandom_range(0, 9);
                1:       y = $urandom_range(1, 5000);
                default: y = $urandom;
            endcase
            run_op(o, x, y, 5'($urandom_range(0, 31)));
        end

        // 8-bit instance: latency WIDTH, then check the remainder via MFHI.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            x8 = (i == 0) ? 8'd200 : 8'($urandom);
            y8 = (i == 0) ? 8'd3 : 8'($urandom_range(1, 255));
            v8 = 1'b1; op8 = 4'd7; a8 = x8; b8 = y8;
            @(negedge clk);
            v8 = 1'b0;
            k = 1;
            while (ov8 !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("w8_latency", 64'(k), 64'd9);
            chk("w8_quot", 64'(od8), 64'(x8 / y8));
            v8 = 1'b1; op8 = 4'd8;
            @(negedge clk);
            v8 = 1'b0;
            chk("w8_rem", 64'(od8), 64'(x8 % y8));
            chk("w8_rem_valid", 64'(ov8), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_unit_mc.md
# exec_unit_mc

Parametrised multi-cycle execute-stage unit for the five-stage pipeline. Replaces the fixed 32-bit combinational ALU wrapper with one block that has width-parametrised ALU and shift ops, an iterative unsigned divider, and internal Hi/Lo registers. A valid/ready handshake lets the pipeline stall while a divide is in flight. It sits between ID/EX and EX/MEM; `out_data` and `zero` feed the EX/MEM register.

## Interface
- `WIDTH`, 32: datapath width; must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clk`.
- `in_valid` input 1: operation request.
- `in_ready` output 1: the unit can accept a request this cycle.
- `op` input 4: operation code. 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 SRL, 6 SLL, 7 DIVU, 8 MFHI, 9 MFLO; 10–15 illegal.
- `dataA` input WIDTH: operand A (rs).
- `dataB` input WIDTH: operand B (rt, or the already-extended immediate).
- `shamt` input SHW: shift amount for SRL/SLL.
- `flush` input 1: abort an in-flight divide.
- `out_valid` output 1: one-cycle pulse; a result is present on `out_data`.
- `out_data` output WIDTH: registered result.
- `zero` output 1: registered; set when the result is all zeros.
- `illegal` output 1: registered; set when the op code was illegal. Valid with `out_valid`.

## Operation
- States: IDLE, DIV.
- `in_ready` = (state == IDLE) && `reset` high.
- A request is accepted on an edge where `in_valid` && `in_ready`. Operands and op are sampled only at that edge.
- Single-cycle ops (0–6, 8, 9, illegal):
  - `out_data`, `zero`, `illegal` are written at the accept edge, and `out_valid` is 1 for the next cycle.
  - State stays IDLE, so back-to-back requests are accepted every cycle.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; there is no overflow flag.
  - SLT gives 1 when signed A < signed B, else 0, zero-extended.
  - SRL is logical right shift of B by `shamt`; SLL is left shift of B by `shamt`.
- MFHI/MFLO return the current Hi/Lo. A DIVU that completes on the same edge is not visible.
- Illegal op: `out_data` = 0, `zero` = 1, `illegal` = 1.
- DIVU, B ≠ 0 (restoring divide, one quotient bit per cycle):
  - At the accept edge: load dividend and divisor, clear the partial remainder, set counter = WIDTH, go to DIV.
  - Each DIV cycle: shift, trial-subtract, set one quotient bit, decrement counter.
  - On the edge where the counter reaches 0:
    - Lo ← quotient, Hi ← remainder.
    - `out_data` ← quotient, `zero` ← (quotient == 0).
    - `out_valid` pulses for the following cycle; go to IDLE.
- DIVU, B == 0: handled as a single-cycle op.
  - Lo ← all ones, Hi ← A, `out_data` ← all ones, `zero` = 0.
  - The divider does not start.
- `flush` high in DIV: on that edge go to IDLE, Hi/Lo unchanged, no `out_valid`.
- `flush` in IDLE has no effect, and it does not block an accept on the same edge.
- `in_valid` during DIV is ignored because `in_ready` = 0. The requester must hold it.
- `out_data`, `zero` and `illegal` hold their last value while `out_valid` = 0.

## Timing
- Reset (`reset` low at an edge):
  - state = IDLE, counter = 0, Hi = Lo = 0.
  - `out_valid` = 0, `out_data` = 0, `zero` = 0, `illegal` = 0.
  - `in_ready` = 0 while `reset` is low.
  - Reset mid-divide aborts it with no result.
- Single-cycle op accepted at edge N: `out_valid` is high between edges N and N+1.
- DIVU (B ≠ 0) accepted at edge N:
  - `in_ready` is low from after edge N through edge N+WIDTH.
  - Hi/Lo update at edge N+WIDTH, and `out_valid` is high between edges N+WIDTH and N+WIDTH+1.
  - `in_ready` returns high in that same cycle, so a new request can be accepted at edge N+WIDTH+1.
- `flush` and counter expiry on the same edge: `flush` wins. No result, Hi/Lo unchanged.
- At most one `out_valid` pulse per accepted request. There is no output backpressure.

## Test plan
- Reset then ADD 0x7FFFFFFF + 1 (WIDTH=32) → next cycle `out_valid`=1, `out_data`=0x80000000, `zero`=0. SUB 5−5 on the following cycle → 0, `zero`=1, no bubble.
- SLT −1 vs 1 → 1. SRL 0x80000000 by 31 → 1. SLL 1 by 4 → 0x10. Op 12 → `out_data`=0, `illegal`=1.
- DIVU 100/7 accepted at edge N → `in_ready` low for 32 cycles, `out_valid` after edge N+32 with `out_data`=14. MFHI → 2, MFLO → 14.
- DIVU 9/0 → one-cycle result 0xFFFFFFFF; MFHI → 9; the state never enters DIV.
- DIVU 100/7 with `flush` at cycle 10 → no `out_valid`, MFLO still returns the previous Lo, `in_ready` high the cycle after the flush.
- `reset` low mid-divide, then release → Hi=Lo=0, `out_valid` never pulses. Repeat the divide test with WIDTH=8 (200/3 → 66 r 2, 8-cycle latency).
